// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the word-addressed memory responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;

  // Bit used to fill rdata when an access falls outside the implemented words.
  localparam logic ERR_FILL = 1'b1;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Responder end of the CPU fetch/load/store bus: req/ack handshake with
// programmable wait states, plus a side-band preload port usable while idle.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_p0;
  logic              we_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              accept;
  logic              req_in_range;
  logic              load_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // The preload port has priority; a coincident req is simply resampled next cycle.
  assign accept        = (state == IDLE) && req && !load_en;
  assign req_in_range  = {1'b0, addr_p0} < DEPTH_LIM;
  assign load_in_range = {1'b0, load_addr} < DEPTH_LIM;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_p0;
    mem_wdata = wdata_p0;
    if (!rst) begin
      if (state == IDLE && load_en) begin
        mem_we    = load_in_range;
        mem_waddr = load_addr;
        mem_wdata = load_data;
      end else if (state == RESP) begin
        mem_we = we_p0 && req_in_range;
      end
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (mem_waddr),
    .wr_data (mem_wdata),
    .rd_addr (addr_p0),
    .rd_data (mem_rdata)
  );

  // Request capture stage: held for the whole transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= addr;
      we_p0    <= we;
      wdata_p0 <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      rdata <= '0;
      cnt   <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          busy <= accept;
          if (accept) begin
            cnt   <= WAIT_INIT;
            state <= (WAIT_CYCLES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          ack   <= 1'b1;
          state <= IDLE;
          if (!req_in_range) begin
            err   <= 1'b1;
            rdata <= {DATA_W{ERR_FILL}};
          end else if (we_p0) begin
            rdata <= '0;
          end else begin
            rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (2 waits/256 words, 0 waits, 2 waits/200 words)
// share one stimulus stream; each transaction's ack timing and data are recorded per instance.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  load_addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] load_data = '0;

  logic [15:0] rdata_v [3];
  logic [2:0]  ack_v, err_v, busy_v;

  int          n_checks = 0;
  int          n_fail = 0;
  int          ack_k [3];
  int          ack_n [3];
  int          busy_n [3];
  logic [15:0] rd_at [3];
  logic        err_at [3];
  int          n_ack;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(2)) dut_main (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_zw (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut_small (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[2]), .ack(ack_v[2]), .err(err_v[2]), .busy(busy_v[2]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // k = 0 is sampled just after the edge that accepts the request.
  task automatic txn(input logic w, input logic [7:0] a, input logic [15:0] d,
                     input bit pre_load, input bit mid_load);
    for (int i = 0; i < 3; i++) begin
      ack_k[i]  = -1;
      ack_n[i]  = 0;
      busy_n[i] = 0;
      rd_at[i]  = '0;
      err_at[i] = 1'b0;
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    if (pre_load) begin
      load_en = 1'b1; load_addr = 8'h30; load_data = 16'h3333;
      tick();
      load_en = 1'b0;
    end
    tick();
    req = 1'b0; we = ~w; addr = 8'hEE; wdata = 16'hDEAD;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i]) busy_n[i]++;
        if (ack_v[i]) begin
          ack_n[i]++;
          ack_k[i]  = k;
          rd_at[i]  = rdata_v[i];
          err_at[i] = err_v[i];
        end
      end
      if (mid_load && k == 1) begin
        load_en = 1'b1; load_addr = 8'h21; load_data = 16'hDEAD;
      end else begin
        load_en = 1'b0;
      end
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_ack", ack_v[0], 1'b0);
    check("rst_busy", busy_v[0], 1'b0);
    check("rst_err", err_v[0], 1'b0);
    check("rst_rdata", rdata_v[0], 16'h0000);
    check("rst_zw_ack", ack_v[1], 1'b0);
    rst = 1'b0;
    tick();

    load_word(8'h05, 16'h1234);
    load_word(8'h03, 16'hA5A5);
    load_word(8'h70, 16'h7070);
    load_word(8'h21, 16'h2121);

    txn(1'b0, 8'h05, 16'h0000, 1'b0, 1'b0);
    check("rd5_lat", ack_k[0], 3);
    check("rd5_data", rd_at[0], 16'h1234);
    check("rd5_err", err_at[0], 1'b0);
    check("rd5_ackpulse", ack_n[0], 1);
    check("rd5_busy_cycles", busy_n[0], 4);
    check("rd5_hold", rdata_v[0], 16'h1234);
    check("rd5_busy_idle", busy_v[0], 1'b0);
    check("zw_lat", ack_k[1], 1);
    check("zw_busy_cycles", busy_n[1], 2);
    check("zw_data", rd_at[1], 16'h1234);
    check("small_rd5_data", rd_at[2], 16'h1234);

    txn(1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0);
    check("wr10_lat", ack_k[0], 3);
    check("wr10_rdata", rd_at[0], 16'h0000);
    check("wr10_err", err_at[0], 1'b0);
    txn(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
    check("rd10_data", rd_at[0], 16'hBEEF);
    check("zw_rd10_data", rd_at[1], 16'hBEEF);

    txn(1'b0, 8'hF0, 16'h0000, 1'b0, 1'b0);
    check("oor_rd_ack", ack_n[2], 1);
    check("oor_rd_err", err_at[2], 1'b1);
    check("oor_rd_data", rd_at[2], 16'hFFFF);
    check("inr_rd_err", err_at[0], 1'b0);
    txn(1'b1, 8'hF0, 16'h5555, 1'b0, 1'b0);
    check("oor_wr_lat", ack_k[2], 3);
    check("oor_wr_err", err_at[2], 1'b1);
    check("inr_wr_err", err_at[0], 1'b0);
    txn(1'b0, 8'h70, 16'h0000, 1'b0, 1'b0);
    check("oor_alias_70", rd_at[2], 16'h7070);
    txn(1'b0, 8'hF0, 16'h0000, 1'b0, 1'b0);
    check("inr_rdF0_data", rd_at[0], 16'h5555);

    txn(1'b0, 8'h30, 16'h0000, 1'b1, 1'b0);
    check("loadprio_lat", ack_k[0], 3);
    check("loadprio_data", rd_at[0], 16'h3333);
    check("loadprio_zw_lat", ack_k[1], 1);

    txn(1'b0, 8'h21, 16'h0000, 1'b0, 1'b1);
    check("midload_rd", rd_at[0], 16'h2121);
    txn(1'b0, 8'h21, 16'h0000, 1'b0, 1'b0);
    check("midload_ignored", rd_at[0], 16'h2121);
    check("idle_load_zw", rd_at[1], 16'hDEAD);

    req = 1'b1; we = 1'b1; addr = 8'h03; wdata = 16'h0BAD;
    tick();
    req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort_ack", ack_v[0], 1'b0);
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_err", err_v[0], 1'b0);
    check("abort_rdata", rdata_v[0], 16'h0000);
    rst = 1'b0;
    n_ack = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack_v[0]) n_ack++;
    end
    check("abort_no_ack", n_ack, 0);
    txn(1'b0, 8'h03, 16'h0000, 1'b0, 1'b0);
    check("abort_mem_kept", rd_at[0], 16'hA5A5);
    check("abort_mem_kept_small", rd_at[2], 16'hA5A5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
